// File: rtl/mac_pkg.sv
// Constants shared by the precision-scalable MAC datapath and its result drain:
// precision codes, lane geometry and the drain FSM state encoding.
package mac_pkg;

  localparam int ACC_W = 56;
  localparam int OUT_W = 8;
  localparam int SH_W  = 6;

  localparam logic [1:0] PREC_FULL = 2'b00;
  localparam logic [1:0] PREC_W4   = 2'b01;
  localparam logic [1:0] PREC_W2   = 2'b10;
  localparam logic [1:0] PREC_RSV  = 2'b11;

  localparam int LANE_W_FULL = 56;
  localparam int LANE_W_W4   = 28;
  localparam int LANE_W_W2   = 14;

  localparam logic [SH_W-1:0] SHIFT_MAX = 6'd55;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    EMIT = 2'b10
  } drain_state_t;

  function automatic logic [2:0] nlanes(input logic [1:0] prec);
    case (prec)
      PREC_FULL: nlanes = 3'd1;
      PREC_W4:   nlanes = 3'd2;
      PREC_W2:   nlanes = 3'd4;
      default:   nlanes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mac_requant_sat.sv
// Requantizes one signed accumulator lane to int8: round-half-up arithmetic
// right shift followed by saturation.
module mac_requant_sat
  import mac_pkg::*;
(
  input  logic [ACC_W-1:0] lane,
  input  logic [SH_W-1:0]  shift,
  output logic [OUT_W-1:0] q
);

  localparam logic signed [ACC_W:0] SAT_MAX = 57'sd127;
  localparam logic signed [ACC_W:0] SAT_MIN = -57'sd128;

  logic signed [ACC_W:0] x;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] y;

  // One guard bit above the lane keeps x + 2^(s-1) from overflowing.
  always_comb begin
    x   = {lane[ACC_W-1], lane};
    rnd = '0;
    if (shift != '0) rnd = {{ACC_W{1'b0}}, 1'b1} << (shift - 6'd1);
    y = (x + rnd) >>> shift;
    if (y > SAT_MAX)      q = 8'h7F;
    else if (y < SAT_MIN) q = 8'h80;
    else                  q = y[OUT_W-1:0];
  end

endmodule

// File: rtl/mac_result_drain.sv
// Drains one packed MAC accumulator word as a stream of requantized int8 lanes
// over a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for start; captures word, precision and clamped shift
//   CALC  | one cycle to register the requantized lane into the output regs
//   EMIT  | out_valid high, outputs held until the consumer accepts
module mac_result_drain
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       prec_level,
  input  logic [ACC_W-1:0] acc_in,
  input  logic [SH_W-1:0]  shift,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic             done,
  output logic             err
);

  drain_state_t     state;
  logic [ACC_W-1:0] cap_acc;
  logic [1:0]       cap_prec;
  logic [SH_W-1:0]  cap_shift;
  logic [1:0]       lane_cnt;
  logic [ACC_W-1:0] lane_val;
  logic [OUT_W-1:0] req_q;

  // Select the current lane and sign-extend it to the full accumulator width.
  always_comb begin
    lane_val = '0;
    case (cap_prec)
      PREC_FULL: lane_val = cap_acc;
      PREC_W4: begin
        if (lane_cnt[0]) lane_val = {{LANE_W_W4{cap_acc[55]}}, cap_acc[55:28]};
        else             lane_val = {{LANE_W_W4{cap_acc[27]}}, cap_acc[27:0]};
      end
      PREC_W2: begin
        case (lane_cnt)
          2'd0:    lane_val = {{(ACC_W-LANE_W_W2){cap_acc[13]}}, cap_acc[13:0]};
          2'd1:    lane_val = {{(ACC_W-LANE_W_W2){cap_acc[27]}}, cap_acc[27:14]};
          2'd2:    lane_val = {{(ACC_W-LANE_W_W2){cap_acc[41]}}, cap_acc[41:28]};
          default: lane_val = {{(ACC_W-LANE_W_W2){cap_acc[55]}}, cap_acc[55:42]};
        endcase
      end
      default: lane_val = '0;
    endcase
  end

  mac_requant_sat u_requant (
    .lane  (lane_val),
    .shift (cap_shift),
    .q     (req_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cap_acc   <= '0;
      cap_prec  <= PREC_FULL;
      cap_shift <= '0;
      lane_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (prec_level == PREC_RSV) begin
              err <= 1'b1;
            end else begin
              cap_acc   <= acc_in;
              cap_prec  <= prec_level;
              cap_shift <= (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
              lane_cnt  <= '0;
              busy      <= 1'b1;
              state     <= CALC;
            end
          end
        end
        CALC: begin
          out_data  <= req_q;
          out_lane  <= lane_cnt;
          out_last  <= ({1'b0, lane_cnt} == (nlanes(cap_prec) - 3'd1));
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              lane_cnt <= lane_cnt + 2'd1;
              state    <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: directed cases with hand-computed
// values plus randomized words checked against a lane-list reference model.
module tb_mac_result_drain;

  typedef struct {
    logic [7:0] data;
    logic [1:0] lane;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  prec_level;
  logic [55:0] acc_in;
  logic [5:0]  shift;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        done;
  logic        err;

  int    n_chk = 0;
  int    n_fail = 0;
  int    done_cnt = 0;
  bit    mon_en = 1'b0;
  bit    done_due = 1'b0;
  bit    rand_ready = 1'b0;
  beat_t exp_q[$];
  beat_t act_q[$];

  always #5 clk = ~clk;

  mac_result_drain dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .prec_level (prec_level),
    .acc_in     (acc_in),
    .shift      (shift),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Signed value of lane idx when the word is split into lanes of w bits.
  function automatic longint lane_of(input logic [55:0] a, input int w, input int idx);
    logic [55:0] t;
    longint v;
    t = a >> (w * idx);
    v = 0;
    for (int b = 0; b < w; b++) v[b] = t[b];
    if (t[w-1]) v = v - (longint'(1) <<< w);
    return v;
  endfunction

  function automatic logic [7:0] ref_q(input longint x, input int s_in);
    int s;
    longint y;
    s = (s_in > 55) ? 55 : s_in;
    if (s == 0) y = x;
    else        y = (x + (longint'(1) <<< (s - 1))) >>> s;
    if (y > 127)  return 8'h7F;
    if (y < -128) return 8'h80;
    return y[7:0];
  endfunction

  task automatic model_push(input logic [1:0] p, input logic [55:0] a, input logic [5:0] s);
    int n;
    beat_t b;
    case (p)
      2'b00:   n = 1;
      2'b01:   n = 2;
      2'b10:   n = 4;
      default: n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      b.data = ref_q(lane_of(a, 56 / n, i), int'(s));
      b.lane = 2'(i);
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // Compare process: every beat shown on the bus must match the model front.
  always @(negedge clk) begin
    if (rstn && mon_en) begin
      chk("done_pulse", longint'(done), longint'(done_due));
      done_due = 1'b0;
      if (done) done_cnt++;
      if (out_valid) begin
        chk("busy_while_valid", longint'(busy), 1);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0d lane %0d, none expected at %0t",
                   out_data, out_lane, $time);
        end else begin
          chk("out_data", longint'(out_data), longint'(exp_q[0].data));
          chk("out_lane", longint'(out_lane), longint'(exp_q[0].lane));
          chk("out_last", longint'(out_last), longint'(exp_q[0].last));
          if (out_ready) begin
            beat_t b;
            b.data = out_data;
            b.lane = out_lane;
            b.last = out_last;
            act_q.push_back(b);
            if (exp_q[0].last) done_due = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input logic [1:0] p, input logic [55:0] a, input logic [5:0] s);
    @(posedge clk); #1;
    start = 1'b1;
    prec_level = p;
    acc_in = a;
    shift = s;
    model_push(p, a, s);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_after_start", longint'(err), longint'(p == 2'b11));
    chk("busy_after_start", longint'(busy), longint'(p != 2'b11));
    chk("valid_latency_1", longint'(out_valid), 0);
    if (p != 2'b11) begin
      @(negedge clk);
      chk("valid_latency_2", longint'(out_valid), 1);
    end
  endtask

  task automatic wait_idle(input bit noise);
    int n;
    logic [63:0] r;
    n = 0;
    do begin
      @(posedge clk); #1;
      if (noise) begin
        r = {$urandom, $urandom};
        acc_in = r[55:0];
        prec_level = 2'($urandom_range(0, 3));
        shift = 6'($urandom_range(0, 63));
      end
      start = noise && busy && ($urandom_range(0, 7) == 0);
      n++;
    end while (busy && n < 2000);
    start = 1'b0;
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: busy still 1 after %0d cycles", n);
    end
    @(negedge clk); #1;
    chk("model_queue_empty", longint'(exp_q.size()), 0);
  endtask

  task automatic chk_beat(input int idx, input logic [7:0] d, input logic [1:0] l, input logic last);
    if (act_q.size() > idx) begin
      chk("beat_data_lit", longint'(act_q[idx].data), longint'(d));
      chk("beat_lane_lit", longint'(act_q[idx].lane), longint'(l));
      chk("beat_last_lit", longint'(act_q[idx].last), longint'(last));
    end else begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_missing: got %0d beats, beat %0d required", act_q.size(), idx);
    end
  endtask

  initial begin
    int dc;
    int found;
    rstn = 1'b0;
    start = 1'b0;
    prec_level = 2'b00;
    acc_in = '0;
    shift = '0;
    out_ready = 1'b0;
    #22;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_last", longint'(out_last), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_data", longint'(out_data), 0);
    chk("rst_lane", longint'(out_lane), 0);
    rstn = 1'b1;
    mon_en = 1'b1;

    // 1: full precision, single beat
    @(posedge clk); #1; out_ready = 1'b1;
    act_q.delete();
    dc = done_cnt;
    issue(2'b00, 56'd1000, 6'd3);
    wait_idle(1'b0);
    chk("t1_beats", longint'(act_q.size()), 1);
    chk_beat(0, 8'h7D, 2'd0, 1'b1);
    chk("t1_done", longint'(done_cnt - dc), 1);

    // 2: four 14-bit lanes with saturation on the top two
    act_q.delete();
    issue(2'b10, {14'h2000, 14'h1FFF, 14'd100, 14'h3FFB}, 6'd1);
    wait_idle(1'b0);
    chk("t2_beats", longint'(act_q.size()), 4);
    chk_beat(0, 8'hFE, 2'd0, 1'b0);
    chk_beat(1, 8'd50, 2'd1, 1'b0);
    chk_beat(2, 8'h7F, 2'd2, 1'b0);
    chk_beat(3, 8'h80, 2'd3, 1'b1);

    // 3: two 28-bit lanes, consumer stalls the first beat
    act_q.delete();
    dc = done_cnt;
    @(posedge clk); #1; out_ready = 1'b0;
    issue(2'b01, {28'h7FFFFFF, 28'hFFFFC18}, 6'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", longint'(out_valid), 1);
      chk("t3_stall_data", longint'(out_data), longint'(8'hC2));
      chk("t3_stall_lane", longint'(out_lane), 0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    wait_idle(1'b0);
    chk("t3_beats", longint'(act_q.size()), 2);
    chk_beat(0, 8'hC2, 2'd0, 1'b0);
    chk_beat(1, 8'h7F, 2'd1, 1'b1);
    chk("t3_done", longint'(done_cnt - dc), 1);

    // 4: reserved precision
    dc = done_cnt;
    issue(2'b11, 56'h12345, 6'd2);
    @(negedge clk);
    chk("t4_err_single", longint'(err), 0);
    chk("t4_valid", longint'(out_valid), 0);
    chk("t4_busy", longint'(busy), 0);
    chk("t4_done", longint'(done_cnt - dc), 0);

    // 5: clamped shift and a start during the drain
    act_q.delete();
    dc = done_cnt;
    issue(2'b00, 56'h7F_FFFF_FFFF_FFFF, 6'd60);
    #1;
    start = 1'b1;
    prec_level = 2'b00;
    acc_in = 56'd5;
    shift = 6'd0;
    @(posedge clk); #1; start = 1'b0;
    wait_idle(1'b0);
    repeat (4) @(negedge clk);
    chk("t5_beats", longint'(act_q.size()), 1);
    chk_beat(0, 8'd1, 2'd0, 1'b1);
    chk("t5_done", longint'(done_cnt - dc), 1);
    chk("t5_busy", longint'(busy), 0);

    // 6: reset during EMIT of lane 2
    act_q.delete();
    dc = done_cnt;
    issue(2'b10, 56'hA5_5A3C_C3F0_0F96, 6'd3);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_lane == 2'd2) begin
        out_ready = 1'b0;
        found = 1;
      end
    end
    chk("t6_reached_lane2", longint'(found), 1);
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", longint'(out_valid), 0);
    chk("t6_rst_busy", longint'(busy), 0);
    chk("t6_rst_data", longint'(out_data), 0);
    chk("t6_rst_lane", longint'(out_lane), 0);
    chk("t6_rst_last", longint'(out_last), 0);
    exp_q.delete();
    act_q.delete();
    done_due = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", longint'(done_cnt - dc), 0);
    @(posedge clk); #1; out_ready = 1'b1;
    issue(2'b10, 56'h01_2345_6789_ABCD, 6'd2);
    wait_idle(1'b0);
    chk("t6_fresh_beats", longint'(act_q.size()), 4);
    if (act_q.size() > 0) chk("t6_fresh_lane0", longint'(act_q[0].lane), 0);

    // Randomized words with random backpressure and input noise while busy
    rand_ready = 1'b1;
    for (int k = 0; k < 150; k++) begin
      logic [63:0] r;
      logic [1:0]  p;
      logic [5:0]  s;
      r = {$urandom, $urandom};
      p = 2'($urandom_range(0, 3));
      s = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 12)) : 6'($urandom_range(0, 63));
      issue(p, r[55:0], s);
      wait_idle(1'b1);
    end
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
